// File: rtl/sha1_padder.sv
// rtl/sha1_padder.sv - SHA-1 message padder: packs bytes into 512-bit blocks, appends 0x80, zeros and the bit length
// Optional block counter output blk_cnt is enabled by defining SHA1_PADDER_BLKCNT_EN.
module sha1_padder (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] block,
  output logic         block_valid,
  output logic         block_last,
  input  logic         block_ready
`ifdef SHA1_PADDER_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_OUT, S_TAIL} state_t;
  typedef enum logic [1:0] {T_NONE, T_ZERO, T_MARK} tail_t;

  state_t       state_q, state_d;
  tail_t        tail_q, tail_d;
  logic [5:0]   idx_q, idx_d;
  logic [31:0]  len_q, len_d;
  logic [6:0]   p_q, p_d;
  logic [511:0] block_q, block_d;
  logic         last_q, last_d;
  logic [63:0]  len_bits;

  // Bit offset of byte b: word b/4 occupies [32k+31:32k], byte 0 of a word is its top byte.
  function automatic logic [8:0] byte_pos(input logic [5:0] b);
    return {b[5:2], ~b[1:0], 3'b000};
  endfunction

  assign in_ready    = (state_q == S_FILL);
  assign block_valid = (state_q == S_OUT);
  assign block_last  = last_q;
  assign block       = block_q;
  assign len_bits    = {29'd0, len_q, 3'b000};

  // Next-state and datapath: byte capture, padding, tail block construction.
  always_comb begin
    state_d = state_q;
    tail_d  = tail_q;
    idx_d   = idx_q;
    len_d   = len_q;
    p_d     = p_q;
    block_d = block_q;
    last_d  = last_q;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          block_d[byte_pos(idx_q) +: 8] = in_data;
          idx_d = idx_q + 6'd1;
          len_d = len_q + 32'd1;
          if (in_last) begin
            p_d     = {1'b0, idx_q} + 7'd1;
            state_d = S_PAD;
          end else if (idx_q == 6'd63) begin
            last_d  = 1'b0;
            state_d = S_OUT;
          end
        end
      end
      S_PAD: begin
        // Marker at byte p, zeros after it; p=64 leaves the full data block untouched.
        for (int b = 0; b < 64; b++) begin
          if (7'(b) == p_q) begin
            block_d[byte_pos(6'(b)) +: 8] = 8'h80;
          end else if (7'(b) > p_q) begin
            block_d[byte_pos(6'(b)) +: 8] = 8'h00;
          end
        end
        if (p_q <= 7'd55) begin
          block_d[479:448] = len_bits[63:32];
          block_d[511:480] = len_bits[31:0];
          last_d = 1'b1;
          tail_d = T_NONE;
        end else if (p_q <= 7'd63) begin
          last_d = 1'b0;
          tail_d = T_ZERO;
        end else begin
          last_d = 1'b0;
          tail_d = T_MARK;
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (block_ready) begin
          if (last_q) begin
            len_d   = 32'd0;
            idx_d   = 6'd0;
            tail_d  = T_NONE;
            last_d  = 1'b0;
            state_d = S_FILL;
          end else if (tail_q != T_NONE) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_TAIL: begin
        // Extra block when the length did not fit behind the marker.
        block_d = '0;
        if (tail_q == T_MARK) begin
          block_d[31:24] = 8'h80;
        end
        block_d[479:448] = len_bits[63:32];
        block_d[511:480] = len_bits[31:0];
        last_d  = 1'b1;
        state_d = S_OUT;
      end
      default: state_d = S_FILL;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      tail_q  <= T_NONE;
      idx_q   <= 6'd0;
      len_q   <= 32'd0;
      p_q     <= 7'd0;
      block_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      p_q     <= p_d;
      block_q <= block_d;
      last_q  <= last_d;
    end
  end

`ifdef SHA1_PADDER_BLKCNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        clr_q, clr_d;

  // Count block handshakes; restart at the first handshake of the next message.
  always_comb begin
    cnt_d = cnt_q;
    clr_d = clr_q;
    if (state_q == S_OUT && block_ready) begin
      cnt_d = (clr_q ? 16'd0 : cnt_q) + 16'd1;
      clr_d = last_q;
    end
  end

  // Block counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
      clr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clr_q <= clr_d;
    end
  end

  assign blk_cnt = cnt_q;
`endif

endmodule
